// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit: opcodes, flag bit positions,
// FSM state encoding and a helper that packs the Alu flags into one vector.
package alu_issue_unit_pkg;

    localparam int DATA_W = 32;
    localparam int FLAG_W = 3;

    // Opcodes driven onto Alu.ALUCtl
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    // Bit positions inside a {cout, overflow, zero} flag vector
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_COUT = 2;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic flags_t pack_flags(input logic cout, input logic ovf, input logic zero);
        flags_t f;
        f            = '0;
        f[FLAG_COUT] = cout;
        f[FLAG_OVF]  = ovf;
        f[FLAG_ZERO] = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Command and response handshake bundle between a host and the issue unit.
// The master drives commands and accepts responses; the issue unit is the slave.
interface alu_issue_unit_if
    import alu_issue_unit_pkg::*;
#(
    parameter int AW = 3
);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [AW-1:0]       cmd_rd;
    logic [AW-1:0]       cmd_rs1;
    logic [AW-1:0]       cmd_rs2;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_r;
    flags_t              rsp_flags;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_r, rsp_flags
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
        output cmd_ready, rsp_valid, rsp_r, rsp_flags
    );

endinterface

// File: rtl/alu_issue_unit_regfile.sv
// NREGS x 32 register file with one write port and three combinational
// read ports (two operand reads and one debug read). Register 0 is hardwired
// to zero: writes to it are discarded and reads always return zero.
module alu_issue_unit_regfile
    import alu_issue_unit_pkg::*;
#(
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [AW-1:0]     rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    // Next register contents: apply the single write unless it targets register 0
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en && (wr_addr != '0)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Register storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : mem_q[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : mem_q[rs2_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Operand/issue stage for an external combinational Alu. Accepts register
// addressed commands, presents registered operands and opcode to the Alu for
// one cycle, writes the result back, and returns result plus flags over a
// response handshake. The last completed command's flags stay in status.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_unit_if.slave    bus,
    input  logic               host_we,
    input  logic [AW-1:0]      host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic [1:0]         alu_ctl,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_r,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    input  logic               alu_cout,
    output flags_t             status,
    input  logic [AW-1:0]      dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_e             state_q,     state_d;
    logic [1:0]         alu_ctl_q,   alu_ctl_d;
    logic [DATA_W-1:0]  alu_a_q,     alu_a_d;
    logic [DATA_W-1:0]  alu_b_q,     alu_b_d;
    logic [AW-1:0]      rd_q,        rd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_r_q,     rsp_r_d;
    flags_t             rsp_flags_q, rsp_flags_d;
    flags_t             status_q,    status_d;

    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    flags_t             alu_flags;

    assign alu_flags = pack_flags(alu_cout, alu_overflow, alu_zero);

    // Single write port: Alu writeback owns it in EXEC, host preload only in IDLE
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = host_addr;
        rf_wdata = host_wdata;
        if (state_q == ST_EXEC) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = alu_r;
        end else if ((state_q == ST_IDLE) && host_we) begin
            rf_we    = 1'b1;
        end
    end

    alu_issue_unit_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (rf_we),
        .wr_addr  (rf_waddr),
        .wr_data  (rf_wdata),
        .rs1_addr (bus.cmd_rs1),
        .rs1_data (rs1_data),
        .rs2_addr (bus.cmd_rs2),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Issue FSM next state: latch operands in IDLE, capture the Alu result in EXEC, wait for consumer in RESP
    always_comb begin
        state_d     = state_q;
        alu_ctl_d   = alu_ctl_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rd_d        = rd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_r_d     = rsp_r_q;
        rsp_flags_d = rsp_flags_q;
        status_d    = status_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    alu_ctl_d = bus.cmd_op;
                    alu_a_d   = rs1_data;
                    alu_b_d   = rs2_data;
                    rd_d      = bus.cmd_rd;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_r_d     = alu_r;
                rsp_flags_d = alu_flags;
                status_d    = alu_flags;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Issue FSM state and registered outputs; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_ctl_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_r_q     <= '0;
            rsp_flags_q <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            alu_ctl_q   <= alu_ctl_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            rsp_flags_q <= rsp_flags_d;
            status_q    <= status_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign alu_ctl       = alu_ctl_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign status        = status_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: connects the unit to a behavioural Alu,
// drives directed and random commands, and checks every response against a
// scoreboard filled from an arithmetic reference model of the register file.
module tb_alu_issue_unit;
    import alu_issue_unit_pkg::*;

    localparam int NREGS = 8;
    localparam int AW    = 3;
    localparam int LIMIT = 200;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] r;
        logic [2:0]  f;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic [1:0]    alu_ctl;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [31:0]   alu_r;
    logic          alu_zero;
    logic          alu_overflow;
    logic          alu_cout;
    flags_t        status;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data;

    logic [31:0]   alu_b_x;
    logic [32:0]   alu_sum;

    int            checks;
    int            failures;
    int            ready_mode;
    logic [31:0]   model_rf [NREGS];
    exp_t          sb [$];

    alu_issue_unit_if #(.AW(AW)) bus ();

    alu_issue_unit #(.NREGS(NREGS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .alu_ctl      (alu_ctl),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_r        (alu_r),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_cout     (alu_cout),
        .status       (status),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational Alu: adder with inverted B and carry-in for SUB
    always_comb begin
        alu_b_x      = (alu_ctl == ALU_SUB) ? ~alu_b : alu_b;
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b_x} + {32'b0, (alu_ctl == ALU_SUB)};
        alu_r        = alu_sum[31:0];
        alu_cout     = alu_sum[32];
        alu_overflow = (alu_a[31] == alu_b_x[31]) && (alu_sum[31] != alu_a[31]);
        if (alu_ctl == ALU_AND) begin
            alu_r        = alu_a & alu_b;
            alu_cout     = 1'b0;
            alu_overflow = 1'b0;
        end else if (alu_ctl == ALU_OR) begin
            alu_r        = alu_a | alu_b;
            alu_cout     = 1'b0;
            alu_overflow = 1'b0;
        end
        alu_zero = (alu_r == 32'h0);
    end

    // Reference result from plain integer arithmetic
    function automatic exp_t refAlu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint ua, ub, sa, sbv, wide, swide;
        logic   cout, ovf;
        ua   = longint'({32'b0, a});
        ub   = longint'({32'b0, b});
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        cout = 1'b0;
        ovf  = 1'b0;
        case (op)
            ALU_AND: e.r = a & b;
            ALU_OR:  e.r = a | b;
            ALU_ADD: begin
                wide  = ua + ub;
                e.r   = wide[31:0];
                cout  = ((wide >>> 32) != 0);
                swide = sa + sbv;
                ovf   = (swide > SMAX) || (swide < SMIN);
            end
            default: begin
                e.r   = a - b;
                cout  = (ua >= ub);
                swide = sa - sbv;
                ovf   = (swide > SMAX) || (swide < SMIN);
            end
        endcase
        e.f = {cout, ovf, (e.r == 32'h0)};
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out after %0d cycles at %0t", name, LIMIT, $time);
    endtask

    // Wait until the unit is idle and every expected response has been consumed
    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(bus.cmd_ready && sb.size() == 0) && n < LIMIT);
        if (!(bus.cmd_ready && sb.size() == 0)) reportTimeout("wait_idle");
    endtask

    task automatic hostWrite(input logic [AW-1:0] addr, input logic [31:0] data);
        waitIdle();
        host_we    = 1'b1;
        host_addr  = addr;
        host_wdata = data;
        @(posedge clk);
        #1;
        host_we = 1'b0;
        if (addr != '0) model_rf[addr] = data;
    endtask

    // Issue one command, optionally with a host write on the same accept edge
    task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] rd,
                                 input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                 input logic do_host, input logic [AW-1:0] h_addr,
                                 input logic [31:0] h_data);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk);
        #1;
        while (!bus.cmd_ready && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            reportTimeout("cmd_ready");
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        host_we       = do_host;
        host_addr     = h_addr;
        host_wdata    = h_data;
        e = refAlu(op, model_rf[rs1], model_rf[rs2]);
        sb.push_back(e);
        if (do_host && h_addr != '0) model_rf[h_addr] = h_data;
        if (rd != '0) model_rf[rd] = e.r;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        host_we       = 1'b0;
    endtask

    task automatic checkDbg(input logic [AW-1:0] addr);
        dbg_addr = addr;
        #1;
        checkOutput($sformatf("dbg_r%0d", addr), dbg_data, model_rf[addr]);
    endtask

    // Consumer side: 0 always ready, 1 random, 2 held low
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every response handshake pops and checks the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_r 0x%08h, expected no response", bus.rsp_r);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_r", bus.rsp_r, e.r);
                    checkOutput("rsp_flags", {29'b0, bus.rsp_flags}, {29'b0, e.f});
                    checkOutput("status", {29'b0, status}, {29'b0, e.f});
                end
            end
        end
    end

    // Main sequence
    initial begin
        exp_t hold_e;
        int   n;
        checks        = 0;
        failures      = 0;
        ready_mode    = 0;
        rst_n         = 1'b0;
        host_we       = 1'b0;
        host_addr     = '0;
        host_wdata    = '0;
        dbg_addr      = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        for (int i = 0; i < NREGS; i++) model_rf[i] = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("reset_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
        checkOutput("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        checkOutput("reset_rsp_r", bus.rsp_r, 32'h0);
        checkOutput("reset_rsp_flags", {29'b0, bus.rsp_flags}, 32'h0);
        checkOutput("reset_status", {29'b0, status}, 32'h0);
        checkOutput("reset_alu_ctl", {30'b0, alu_ctl}, 32'h0);
        checkOutput("reset_alu_a", alu_a, 32'h0);
        checkOutput("reset_alu_b", alu_b, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] directed ADD/SUB/AND cases");
        hostWrite(3'd1, 32'h0000_0001);
        hostWrite(3'd2, 32'h0000_0001);
        applyStimulus(ALU_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 32'h0);
        waitIdle();
        checkDbg(3'd3);
        checkOutput("add_small_r3", dbg_data, 32'h0000_0002);
        checkOutput("add_small_status", {29'b0, status}, 32'h0);

        hostWrite(3'd1, 32'h7FFF_FFFF);
        hostWrite(3'd2, 32'h0000_0001);
        applyStimulus(ALU_ADD, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 32'h0);
        waitIdle();
        checkOutput("add_ovf_status", {29'b0, status}, 32'h2);
        checkDbg(3'd4);

        hostWrite(3'd5, 32'h1234_5678);
        applyStimulus(ALU_SUB, 3'd6, 3'd5, 3'd5, 1'b0, 3'd0, 32'h0);
        waitIdle();
        checkOutput("sub_zero_status", {29'b0, status}, 32'h5);
        checkDbg(3'd6);

        hostWrite(3'd1, 32'hFFFF_FFFF);
        hostWrite(3'd2, 32'h0F0F_0F0F);
        applyStimulus(ALU_AND, 3'd0, 3'd1, 3'd2, 1'b0, 3'd0, 32'h0);
        waitIdle();
        checkDbg(3'd0);
        checkOutput("and_r0_zero", dbg_data, 32'h0);
        hostWrite(3'd0, 32'hAAAA_5555);
        checkDbg(3'd0);

        $display("[TB] same-edge host write and command, rd equals rs1");
        applyStimulus(ALU_OR, 3'd1, 3'd1, 3'd2, 1'b1, 3'd1, 32'h3000_0000);
        waitIdle();
        checkDbg(3'd1);

        $display("[TB] response held back by consumer");
        ready_mode = 2;
        waitIdle();
        applyStimulus(ALU_ADD, 3'd7, 3'd5, 3'd2, 1'b0, 3'd0, 32'h0);
        hold_e = sb[$];
        @(negedge clk);
        checkOutput("exec_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        n = 0;
        while (!bus.rsp_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) reportTimeout("rsp_valid");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                host_we    = 1'b1;
                host_addr  = 3'd5;
                host_wdata = 32'hDEAD_BEEF;
            end else begin
                host_we = 1'b0;
            end
            @(negedge clk);
            checkOutput("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
            checkOutput("hold_rsp_r", bus.rsp_r, hold_e.r);
            checkOutput("hold_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
        end
        ready_mode = 0;
        waitIdle();
        checkDbg(3'd5);
        checkDbg(3'd7);

        $display("[TB] randomized commands");
        ready_mode = 1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                hostWrite(3'($urandom_range(0, NREGS - 1)),
                          ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
            end else begin
                applyStimulus(2'($urandom_range(0, 3)),
                              3'($urandom_range(0, NREGS - 1)),
                              3'($urandom_range(0, NREGS - 1)),
                              3'($urandom_range(0, NREGS - 1)),
                              ($urandom_range(0, 7) == 0),
                              3'($urandom_range(0, NREGS - 1)),
                              $urandom);
            end
        end
        ready_mode = 0;
        waitIdle();
        for (int i = 0; i < NREGS; i++) checkDbg(3'(i));

        $display("[TB] reset during EXEC");
        hostWrite(3'd1, 32'h0000_00F0);
        hostWrite(3'd2, 32'h0000_000F);
        applyStimulus(ALU_OR, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0, 32'h0);
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < NREGS; i++) model_rf[i] = 32'h0;
        #2;
        checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        checkOutput("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
        checkOutput("rst_status", {29'b0, status}, 32'h0);
        checkOutput("rst_alu_a", alu_a, 32'h0);
        for (int i = 0; i < NREGS; i++) checkDbg(3'(i));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        checkOutput("post_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);
        checkDbg(3'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
